// File: rtl/inst_encode_loader_pkg.sv
// Shared RV32I encoding constants, command format codes and loader FSM state encoding.
// The opcode constants are the same values the control decoder matches on.
package inst_encode_loader_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_LW  = 2'b01,
    FMT_SW  = 2'b10,
    FMT_BEQ = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ENC  = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        last;
  } cmd_t;

endpackage

// File: rtl/inst_encode_loader_field_pack.sv
// Combinational packer: command format plus register/immediate fields -> 32-bit RV32I word.
// Fields that a format does not use never reach the output word.
module inst_field_pack
  import inst_encode_loader_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o
);

  // Branch offsets are halfword-aligned, so imm bit 0 carries no information.
  logic unused_imm0;
  assign unused_imm0 = imm_i[0];

  always_comb begin
    word_o = 32'h0;
    unique case (fmt_i)
      FMT_R:   word_o = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPC_RTYPE};
      FMT_LW:  word_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OPC_LOAD};
      FMT_SW:  word_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
      FMT_BEQ: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                         imm_i[4:1], imm_i[11], OPC_BRANCH};
      default: word_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/inst_encode_loader.sv
// Program loader: accepts fielded commands, encodes each to an RV32I word and writes it
// to IMEM at consecutive word addresses, one command every three cycles.
module inst_encode_loader
  import inst_encode_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [1:0]        CmdFmt,
  input  logic [2:0]        CmdFunct3,
  input  logic              CmdFunct7b5,
  input  logic [4:0]        CmdRd,
  input  logic [4:0]        CmdRs1,
  input  logic [4:0]        CmdRs2,
  input  logic [12:0]       CmdImm,
  input  logic              CmdLast,
  output logic              ImemWe,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [31:0]       ImemWdata,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic [ADDR_W:0]   Count
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  cmd_t                cmd_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic                ovf_q;
  logic [31:0]         packed_word;
  logic                accept;
  logic                at_top;

  assign accept = CmdValid && (state_q == ST_IDLE);
  assign at_top = (addr_q == ADDR_MAX);

  inst_field_pack u_pack (
    .fmt_i      (cmd_q.fmt),
    .funct3_i   (cmd_q.funct3),
    .funct7b5_i (cmd_q.funct7b5),
    .rd_i       (cmd_q.rd),
    .rs1_i      (cmd_q.rs1),
    .rs2_i      (cmd_q.rs2),
    .imm_i      (cmd_q.imm),
    .word_o     (packed_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (CmdValid) state_d = ST_ENC;
      ST_ENC:  state_d = ST_WR;
      // Stop at the last address rather than wrapping onto already-written words.
      ST_WR:   state_d = (cmd_q.last || at_top) ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      wdata_q <= 32'h0;
      addr_q  <= ADDR_BASE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q <= '{fmt: fmt_e'(CmdFmt), funct3: CmdFunct3, funct7b5: CmdFunct7b5,
                   rd: CmdRd, rs1: CmdRs1, rs2: CmdRs2, imm: CmdImm, last: CmdLast};
      end
      if (state_q == ST_ENC) begin
        wdata_q <= packed_word;
      end
      if (state_q == ST_WR) begin
        addr_q  <= addr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W+1)'(1);
        if (at_top && !cmd_q.last) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign CmdReady  = (state_q == ST_IDLE);
  assign ImemWe    = (state_q == ST_WR);
  assign ImemAddr  = addr_q;
  assign ImemWdata = wdata_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Overflow  = ovf_q;
  assign Count     = count_q;

endmodule
